// File: rtl/maze_solver.sv
// maze_solver: depth-first search over a 2**XW x 2**YW maze bitmap.
//
// A walker starts at (start_x, start_y) and takes one step per clock, trying
// neighbours in the order N, E, S, W. Each move pushes the cell it leaves onto
// a stack. A dead end pops the walker back one cell. The cells currently on
// the stack, plus the walker's own cell, form the route reported on path_data.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   start               begin a search (accepted in IDLE or DONE only)
//   maze_data           maze bitmap, bit x + W*y, 1 = open; must be held while busy
//   start_x/y, goal_x/y start and goal cells, sampled with start
//   busy                high while initialising or searching
//   done, found         search finished; found = goal reached (valid while done)
//   path_data           cells on the current route, same indexing as maze_data
//   path_len            number of moves on the route (stack depth)
//   cur_x, cur_y        current walker position
module maze_solver #(
  parameter int XW = 4,
  parameter int YW = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [(1<<(XW+YW))-1:0]     maze_data,
  input  logic [XW-1:0]               start_x,
  input  logic [YW-1:0]               start_y,
  input  logic [XW-1:0]               goal_x,
  input  logic [YW-1:0]               goal_y,
  output logic                        busy,
  output logic                        done,
  output logic                        found,
  output logic [(1<<(XW+YW))-1:0]     path_data,
  output logic [XW+YW:0]              path_len,
  output logic [XW-1:0]               cur_x,
  output logic [YW-1:0]               cur_y
);

  localparam int CW    = XW + YW;   // cell index width
  localparam int NCELL = 1 << CW;
  localparam int PW    = CW + 1;    // stack pointer width

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_SEARCH, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     cur_x_q, cur_x_d, start_x_q, start_x_d, goal_x_q, goal_x_d;
  logic [YW-1:0]     cur_y_q, cur_y_d, start_y_q, start_y_d, goal_y_q, goal_y_d;
  logic [NCELL-1:0]  visited_q, visited_d, path_q, path_d;
  logic [PW-1:0]     sp_q, sp_d;
  logic              busy_q, busy_d, done_q, done_d, found_q, found_d;

  logic [CW-1:0]     stack_mem [NCELL];
  logic              push;

  // Because W and H are powers of two, index x + W*y is just {y, x}.
  logic [CW-1:0]     cur_idx, start_idx, nb_idx, pop_idx;
  logic              nb_ok;
  logic [XW-1:0]     x_m1, x_p1;
  logic [YW-1:0]     y_m1, y_p1;
  logic [3:0]        cand_ok;
  logic [CW-1:0]     cand_idx [4];

  assign cur_idx   = {cur_y_q, cur_x_q};
  assign start_idx = {start_y_q, start_x_q};
  assign pop_idx   = stack_mem[sp_q[CW-1:0] - CW'(1)];

  // Neighbour selection: bounds-checked candidates in N, E, S, W order.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (that would infer a latch).
    x_m1        = cur_x_q - XW'(1);
    x_p1        = cur_x_q + XW'(1);
    y_m1        = cur_y_q - YW'(1);
    y_p1        = cur_y_q + YW'(1);
    cand_idx[0] = {y_m1, cur_x_q};
    cand_idx[1] = {cur_y_q, x_p1};
    cand_idx[2] = {y_p1, cur_x_q};
    cand_idx[3] = {cur_y_q, x_m1};
    cand_ok[0]  = (cur_y_q != '0);
    cand_ok[1]  = (cur_x_q != '1);
    cand_ok[2]  = (cur_y_q != '1);
    cand_ok[3]  = (cur_x_q != '0);
    nb_ok       = 1'b0;
    nb_idx      = cur_idx;
    // Scan from W back to N so the highest-priority valid direction wins.
    for (int d = 3; d >= 0; d--) begin
      if (cand_ok[d] && maze_data[cand_idx[d]] && !visited_q[cand_idx[d]]) begin
        nb_ok  = 1'b1;
        nb_idx = cand_idx[d];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    start_x_d = start_x_q;
    start_y_d = start_y_q;
    goal_x_d  = goal_x_q;
    goal_y_d  = goal_y_q;
    visited_d = visited_q;
    path_d    = path_q;
    sp_d      = sp_q;
    busy_d    = busy_q;
    done_d    = done_q;
    found_d   = found_q;
    push      = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_x_d = start_x;
          start_y_d = start_y;
          goal_x_d  = goal_x;
          goal_y_d  = goal_y;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          found_d   = 1'b0;
          state_d   = S_INIT;
        end
      end
      S_INIT: begin
        visited_d = '0;
        path_d    = '0;
        sp_d      = '0;
        cur_x_d   = start_x_q;
        cur_y_d   = start_y_q;
        if (!maze_data[start_idx]) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          found_d = 1'b0;
          state_d = S_DONE;
        end else begin
          visited_d[start_idx] = 1'b1;
          path_d[start_idx]    = 1'b1;
          state_d              = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (cur_x_q == goal_x_q && cur_y_q == goal_y_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          found_d = 1'b1;
          state_d = S_DONE;
        end else if (nb_ok) begin
          push              = 1'b1;
          visited_d[nb_idx] = 1'b1;
          path_d[nb_idx]    = 1'b1;
          cur_x_d           = nb_idx[XW-1:0];
          cur_y_d           = nb_idx[CW-1:XW];
          sp_d              = sp_q + PW'(1);
        end else if (sp_q == '0) begin
          // Exhausted at the start cell: no route, so the start bit goes too.
          path_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          found_d = 1'b0;
          state_d = S_DONE;
        end else begin
          path_d[cur_idx] = 1'b0;
          cur_x_d         = pop_idx[XW-1:0];
          cur_y_d         = pop_idx[CW-1:XW];
          sp_d            = sp_q - PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      start_x_q <= '0;
      start_y_q <= '0;
      goal_x_q  <= '0;
      goal_y_q  <= '0;
      visited_q <= '0;
      path_q    <= '0;
      sp_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      start_x_q <= start_x_d;
      start_y_q <= start_y_d;
      goal_x_q  <= goal_x_d;
      goal_y_q  <= goal_y_d;
      visited_q <= visited_d;
      path_q    <= path_d;
      sp_q      <= sp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
    end
  end

  // NOTE: the stack storage has no reset; an entry is only ever read below
  // the stack pointer, which is reset, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp_q[CW-1:0]] <= cur_idx;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign path_data = path_q;
  assign path_len  = sp_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;

endmodule

// File: doc/maze_solver.md
Name: maze_solver

Overview:
- Reads the 16x16 maze bitmap produced by the team's carver (1 = open path, 0 = wall) and searches it from a start cell to a goal cell.
- Uses a stack-based depth-first walk with one step per clock.
- Outputs a bitmap of the cells on the found route, plus status flags.
- Sits downstream of the carver and upstream of the display/game logic.

Parameters:
XW, 4, coordinate width in bits for x; maze width W = 2**XW
YW, 4, coordinate width in bits for y; maze height H = 2**YW

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous and active-low
start  input  1  begin a search; sampled only in IDLE or DONE
maze_data  input  W*H  maze bitmap, bit index x + W*y, 1 = open; must be stable while busy
start_x  input  XW  start cell x, sampled with start
start_y  input  YW  start cell y, sampled with start
goal_x  input  XW  goal cell x, sampled with start
goal_y  input  YW  goal cell y, sampled with start
busy  output  1  high in INIT and SEARCH
done  output  1  high in DONE; held until the next accepted start
found  output  1  valid while done; 1 = goal reached
path_data  output  W*H  1 = cell lies on the current route; same bit indexing as maze_data
path_len  output  XW+YW+1  number of moves on the route (stack depth)
cur_x  output  XW  current walker x
cur_y  output  YW  current walker y

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE.
  - busy=0, done=0, found=0, path_data=0, path_len=0, cur_x=0, cur_y=0.
  - The visited bitmap and stack pointer are cleared.
  - Reset mid-search aborts immediately and produces no done.
- State IDLE: on an edge with start=1, latch start/goal coordinates and go to INIT. start=1 in INIT or SEARCH is ignored. start=1 in DONE behaves as in IDLE.
- State INIT (1 cycle):
  - Clear visited, path_data and the stack pointer.
  - Set cur=start.
  - If maze_data[start]==0: go to DONE with found=0.
  - Otherwise: set visited[start]=1 and path_data[start]=1, then go to SEARCH.
- State SEARCH, one action per cycle, evaluated in this priority:
  1. cur==goal: go to DONE, found=1.
  2. Else pick the first valid neighbour in the order N (y-1), E (x+1), S (y+1), W (x-1).
     - A neighbour is valid if it is in bounds (no wrap at x=0, x=W-1, y=0, y=H-1), maze_data=1, and visited=0.
     - Action: push cur, set visited[n]=1 and path_data[n]=1, cur=n, stack pointer +1.
  3. Else, if the stack pointer is 0: go to DONE, found=0 (path_data[start] is left at 1 only if found; it is cleared here).
  4. Else: clear path_data[cur], pop into cur, stack pointer -1.
- path_len always equals the stack pointer.
- Stack depth is W*H entries, and the pointer is XW+YW+1 bits. At most W*H-1 pushes can occur, so overflow is impossible.
- Latency from the start-sampling edge to done=1 is 2 + moves + pops edges. For a blocked start cell it is 1 edge.
- Maze bits outside the path are never written; the block only reads maze_data.
- A goal on a wall cell is never reached: the search exhausts and ends with found=0.

Test Plan:
- Straight corridor: maze bits 0..3 open, start (0,0), goal (3,0), pulse start -> done=1 and found=1 exactly 5 edges after the start edge; path_data=0x000F; path_len=3.
- Start equals goal: start=goal=(5,5) with bit 85 open -> done after 2 edges; found=1; path_data has only bit 85 set; path_len=0.
- Backtrack: open cells (0,0),(1,0),(2,0),(3,0),(1,1),(1,2), start (0,0), goal (1,2) -> done after 9 edges; found=1; path_data bits {0,1,17,33} set only; path_len=3.
- Unreachable goal: same maze as the backtrack case with goal (5,5) -> found=0; path_data=0; path_len=0; done held high until the next start.
- Blocked start: maze_data[start]=0 -> done after 1 edge with found=0; busy high for exactly 1 cycle.
- Reset and ignore:
  - Assert rst_n=0 mid-SEARCH, then release -> all outputs return to their reset values; done stays 0.
  - A start pulse while busy=1 leaves the current run's result unchanged.
